i2c_slave_ctrl: RTL and testbench
=================================

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 65535; idle-cycle limit before forced return to IDLE.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start_found  in  1  one-cycle pulse; START or repeated START detected.
REQ-005 stop_found  in  1  one-cycle pulse; STOP detected.
REQ-006 byte_received  in  1  one-cycle pulse; 8 bits shifted in.
REQ-007 ack_prep  in  1  one-cycle pulse; SCL low before ACK bit.
REQ-008 check_ack  in  1  one-cycle pulse; SCL high during ACK bit; sample point for sda_in.
REQ-009 ack_done  in  1  one-cycle pulse; SCL falling after ACK bit.
REQ-010 rw_mode  in  1  R/W bit of received address byte; 1 = master read.
REQ-011 address_match  in  1  received address equals own address.
REQ-012 sda_in  in  1  synchronized SDA level.
REQ-013 rx_fifo_full / tx_fifo_empty  in  1 each  FIFO status flags.
REQ-014 rx_enable  out  1  enables receive shift register.
REQ-015 tx_enable  out  1  enables transmit shift register.
REQ-016 load_data  out  1  one-cycle pulse; load transmit shift register.
REQ-017 read_enable  out  1  one-cycle pulse; pop tx FIFO.
REQ-018 write_enable  out  1  one-cycle pulse; push received byte to rx FIFO.
REQ-019 sda_mode  out  2  SDA output select: 00 release, 01 ACK, 10 NACK, 11 tx data.

Function
REQ-020 States: IDLE, RX_ADDR, ADDR_CHK, ACK_ADDR, NACK, RX_DATA, DATA_CHK, ACK_DATA, LOAD_TX, TX_DATA, CHK_ACK, WAIT_ACK_DONE; all outputs registered or decoded from state only, one-cycle latency from the input pulse.
REQ-021 IDLE: start_found -> RX_ADDR; all other events ignored.
REQ-022 RX_ADDR: rx_enable=1; byte_received -> ADDR_CHK.
REQ-023 ADDR_CHK: on ack_prep, address_match && (!rw_mode || !tx_fifo_empty) -> ACK_ADDR, else -> NACK.
REQ-024 ACK_ADDR: sda_mode=01; on ack_done, rw_mode=1 -> LOAD_TX, rw_mode=0 -> RX_DATA.
REQ-025 NACK: sda_mode=10; ack_done -> IDLE.
REQ-026 RX_DATA: rx_enable=1; byte_received -> DATA_CHK.
REQ-027 DATA_CHK: on ack_prep, rx_fifo_full -> NACK with no push; else write_enable pulses once and -> ACK_DATA.
REQ-028 ACK_DATA: sda_mode=01; ack_done -> RX_DATA.
REQ-029 LOAD_TX: load_data=1 for one cycle, read_enable=1 only if !tx_fifo_empty (empty loads 0xFF); -> TX_DATA next cycle.
REQ-030 TX_DATA: sda_mode=11, tx_enable=1; ack_prep -> CHK_ACK.
REQ-031 CHK_ACK: sda_mode=00; on check_ack, latch sda_in -> WAIT_ACK_DONE.
REQ-032 WAIT_ACK_DONE: sda_mode=00; on ack_done, latched 0 -> LOAD_TX, latched 1 -> IDLE.
REQ-033 stop_found in any state -> IDLE, highest priority.
REQ-034 start_found in any non-IDLE state -> RX_ADDR (repeated start), second priority.
REQ-035 Timeout counter clears on any input pulse and in IDLE; reaching TIMEOUT_CYCLES in a non-IDLE state -> IDLE.
REQ-036 Simultaneous pulses: stop > start > timeout > state-specific event.

Reset
REQ-037 rst=1: state IDLE, timeout counter 0, latched ACK 0, sda_mode=00, all enables and pulses 0; overrides mid-transaction activity in the same edge.

Configuration
REQ-038 I2C_SLAVE_CTRL_GCALL_EN defined: extra input gen_call_match (1 bit); in ADDR_CHK, gen_call_match && !rw_mode is treated as an address match; gen_call_match && rw_mode -> NACK.
REQ-039 I2C_SLAVE_CTRL_GCALL_EN undefined: no gen_call_match port; only address_match is honored.

Structure
REQ-040 Shared package i2c_pkg holds the state enum and the sda_mode constants (SDA_IDLE, SDA_ACK, SDA_NACK, SDA_TX).
REQ-041 The timeout counter is a separate sub-module, i2c_timeout_cnt, with clear, enable and expired signals.

Verification
REQ-042 Write: start, address byte matched with rw=0, two data bytes, stop -> sda_mode 01 during each ACK, write_enable pulsed twice, IDLE after stop.
REQ-043 Read: matched address with rw=1 and tx FIFO nonempty, master ACKs once then NACKs -> load_data pulsed twice, sda_mode 11 during data, IDLE after the NACK ack_done.
REQ-044 Mismatch: address_match=0 -> sda_mode=10 during the ACK bit, then IDLE; no write_enable.
REQ-045 rx_fifo_full=1 at the second data byte -> NACK, no push, IDLE.
REQ-046 Repeated start during RX_DATA -> RX_ADDR; stop and start in the same cycle -> IDLE.
REQ-047 With TIMEOUT_CYCLES=16 and no pulses after entering RX_DATA -> IDLE after 16 cycles; rst asserted mid-TX_DATA -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave controller: FSM state encoding and the
// SDA output-select codes driven on sda_mode.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_ADDR,
    ADDR_CHK,
    ACK_ADDR,
    NACK,
    RX_DATA,
    DATA_CHK,
    ACK_DATA,
    LOAD_TX,
    TX_DATA,
    CHK_ACK,
    WAIT_ACK_DONE
  } state_t;

  localparam logic [1:0] SDA_IDLE = 2'b00;
  localparam logic [1:0] SDA_ACK  = 2'b01;
  localparam logic [1:0] SDA_NACK = 2'b10;
  localparam logic [1:0] SDA_TX   = 2'b11;

endpackage

// File: rtl/i2c_timeout_cnt.sv
// Bus-inactivity counter: expired is asserted during the cycle in which the
// count of consecutive enabled, non-cleared cycles reaches TIMEOUT_CYCLES.
module i2c_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expired = enable && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol FSM sequencing address/data/ACK phases from bit-level
// event pulses. Define I2C_SLAVE_CTRL_GCALL_EN to add general-call support.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       rw_mode,
  input  logic       address_match,
  input  logic       sda_in,
`ifdef I2C_SLAVE_CTRL_GCALL_EN
  input  logic       gen_call_match,
`endif
  input  logic       rx_fifo_full,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       read_enable,
  output logic       write_enable,
  output logic [1:0] sda_mode
);

  state_t state, state_nxt;
  logic   ack_q, ack_nxt;
  logic   load_nxt, read_nxt, write_nxt;
  logic   any_pulse, expired, addr_ok;

  assign any_pulse = start_found | stop_found | byte_received |
                     ack_prep | check_ack | ack_done;

  // A read is only acknowledged when there is data to send.
`ifdef I2C_SLAVE_CTRL_GCALL_EN
  assign addr_ok = gen_call_match ? !rw_mode
                                  : (address_match && (!rw_mode || !tx_fifo_empty));
`else
  assign addr_ok = address_match && (!rw_mode || !tx_fifo_empty);
`endif

  i2c_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (any_pulse || (state == IDLE)),
    .enable  (state != IDLE),
    .expired (expired)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ack_nxt   = ack_q;
    write_nxt = 1'b0;
    if (stop_found) begin
      state_nxt = IDLE;
    end else if (start_found) begin
      state_nxt = RX_ADDR;
    end else if (expired) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:     ;
        RX_ADDR:  if (byte_received) state_nxt = ADDR_CHK;
        ADDR_CHK: if (ack_prep) state_nxt = addr_ok ? ACK_ADDR : NACK;
        ACK_ADDR: if (ack_done) state_nxt = rw_mode ? LOAD_TX : RX_DATA;
        NACK:     if (ack_done) state_nxt = IDLE;
        RX_DATA:  if (byte_received) state_nxt = DATA_CHK;
        DATA_CHK: begin
          if (ack_prep) begin
            state_nxt = rx_fifo_full ? NACK : ACK_DATA;
            write_nxt = !rx_fifo_full;
          end
        end
        ACK_DATA: if (ack_done) state_nxt = RX_DATA;
        LOAD_TX:  state_nxt = TX_DATA;
        TX_DATA:  if (ack_prep) state_nxt = CHK_ACK;
        CHK_ACK: begin
          if (check_ack) begin
            ack_nxt   = sda_in;
            state_nxt = WAIT_ACK_DONE;
          end
        end
        WAIT_ACK_DONE: if (ack_done) state_nxt = ack_q ? IDLE : LOAD_TX;
        default:  state_nxt = IDLE;
      endcase
    end
    load_nxt = (state_nxt == LOAD_TX);
    read_nxt = load_nxt && !tx_fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ack_q        <= 1'b0;
      load_data    <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
    end else begin
      state        <= state_nxt;
      ack_q        <= ack_nxt;
      load_data    <= load_nxt;
      read_enable  <= read_nxt;
      write_enable <= write_nxt;
    end
  end

  always_comb begin
    rx_enable = (state == RX_ADDR) || (state == RX_DATA);
    tx_enable = (state == TX_DATA);
    unique case (state)
      ACK_ADDR, ACK_DATA: sda_mode = SDA_ACK;
      NACK:               sda_mode = SDA_NACK;
      TX_DATA:            sda_mode = SDA_TX;
      default:            sda_mode = SDA_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: table-driven per-cycle vectors plus
// hand-written timeout and mid-transfer reset sequences.
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_found, stop_found, byte_received, ack_prep, check_ack, ack_done;
  logic       rw_mode, address_match, sda_in, rx_fifo_full, tx_fifo_empty;
`ifdef I2C_SLAVE_CTRL_GCALL_EN
  logic       gen_call_match = 1'b0;
`endif
  logic       rx_enable, tx_enable, load_data, read_enable, write_enable;
  logic [1:0] sda_mode;
  logic [6:0] outs;

  int tests = 0;
  int fails = 0;

  i2c_slave_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_found   (start_found),
    .stop_found    (stop_found),
    .byte_received (byte_received),
    .ack_prep      (ack_prep),
    .check_ack     (check_ack),
    .ack_done      (ack_done),
    .rw_mode       (rw_mode),
    .address_match (address_match),
    .sda_in        (sda_in),
`ifdef I2C_SLAVE_CTRL_GCALL_EN
    .gen_call_match(gen_call_match),
`endif
    .rx_fifo_full  (rx_fifo_full),
    .tx_fifo_empty (tx_fifo_empty),
    .rx_enable     (rx_enable),
    .tx_enable     (tx_enable),
    .load_data     (load_data),
    .read_enable   (read_enable),
    .write_enable  (write_enable),
    .sda_mode      (sda_mode)
  );

  always #5 clk = ~clk;

  assign outs = {rx_enable, tx_enable, load_data, read_enable, write_enable, sda_mode};

  // pulse = {start, stop, byte_received, ack_prep, check_ack, ack_done}
  // level = {rw_mode, address_match, sda_in, rx_fifo_full, tx_fifo_empty}
  // exp_out = {rx_en, tx_en, load_data, read_enable, write_enable, sda_mode}
  typedef struct {
    string      name;
    logic [5:0] pulse;
    logic [4:0] level;
    logic [6:0] exp_out;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [5:0] p, input logic [4:0] l,
                              input logic [4:0] e, input logic [1:0] sm);
    vec_t v;
    v.name    = n;
    v.pulse   = p;
    v.level   = l;
    v.exp_out = {e, sm};
    return v;
  endfunction

  task automatic add(input string n, input logic [5:0] p, input logic [4:0] l,
                     input logic [4:0] e, input logic [1:0] sm);
    tbl.push_back(mk(n, p, l, e, sm));
  endtask

  task automatic check(input string n, input logic [6:0] act, input logic [6:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (rx,tx,ld,re,we,sda[1:0])", n, act, exp_v);
    end
  endtask

  task automatic step(input vec_t v);
    {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = v.pulse;
    {rw_mode, address_match, sda_in, rx_fifo_full, tx_fifo_empty} = v.level;
    @(posedge clk);
    #1;
    check(v.name, outs, v.exp_out);
  endtask

  localparam logic [5:0] P_NONE = 6'b000000, P_START = 6'b100000, P_STOP = 6'b010000,
                         P_BYTE = 6'b001000, P_PREP = 6'b000100, P_CHK = 6'b000010,
                         P_DONE = 6'b000001;
  localparam logic [4:0] L_WR   = 5'b01101;  // write, matched
  localparam logic [4:0] L_RD   = 5'b11100;  // read, matched, tx nonempty
  localparam logic [4:0] L_MISS = 5'b00101;  // write, not matched

  initial begin
    // write: two bytes ACKed and pushed, then stop
    add("wr_start",     P_START, L_WR, 5'b10000, 2'b00);
    add("wr_hold",      P_NONE,  L_WR, 5'b10000, 2'b00);
    add("wr_addr_byte", P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("wr_addr_ack",  P_PREP,  L_WR, 5'b00000, 2'b01);
    add("wr_to_rxdata", P_DONE,  L_WR, 5'b10000, 2'b00);
    add("wr_d0_byte",   P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("wr_d0_push",   P_PREP,  L_WR, 5'b00001, 2'b01);
    add("wr_d0_ackhold",P_NONE,  L_WR, 5'b00000, 2'b01);
    add("wr_d0_done",   P_DONE,  L_WR, 5'b10000, 2'b00);
    add("wr_d1_byte",   P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("wr_d1_push",   P_PREP,  L_WR, 5'b00001, 2'b01);
    add("wr_d1_done",   P_DONE,  L_WR, 5'b10000, 2'b00);
    add("wr_stop",      P_STOP,  L_WR, 5'b00000, 2'b00);
    add("idle_ignores", P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("idle_ign_prep",P_PREP,  L_WR, 5'b00000, 2'b00);
    // read: master ACKs first byte, second load from empty FIFO, master NACKs
    add("rd_start",     P_START, L_RD, 5'b10000, 2'b00);
    add("rd_addr_byte", P_BYTE,  L_RD, 5'b00000, 2'b00);
    add("rd_addr_ack",  P_PREP,  L_RD, 5'b00000, 2'b01);
    add("rd_load0",     P_DONE,  L_RD, 5'b00110, 2'b00);
    add("rd_tx0",       P_NONE,  L_RD, 5'b01000, 2'b11);
    add("rd_tx0_hold",  P_NONE,  L_RD, 5'b01000, 2'b11);
    add("rd_chk0",      P_PREP,  L_RD, 5'b00000, 2'b00);
    add("rd_mack",      P_CHK,   5'b11000, 5'b00000, 2'b00);
    add("rd_load1_empty", P_DONE, 5'b11101, 5'b00100, 2'b00);
    add("rd_tx1",       P_NONE,  L_RD, 5'b01000, 2'b11);
    add("rd_chk1",      P_PREP,  L_RD, 5'b00000, 2'b00);
    add("rd_mnack",     P_CHK,   L_RD, 5'b00000, 2'b00);
    add("rd_end_idle",  P_DONE,  L_RD, 5'b00000, 2'b00);
    add("rd_still_idle",P_NONE,  L_RD, 5'b00000, 2'b00);
    // address mismatch
    add("mm_start",     P_START, L_MISS, 5'b10000, 2'b00);
    add("mm_byte",      P_BYTE,  L_MISS, 5'b00000, 2'b00);
    add("mm_nack",      P_PREP,  L_MISS, 5'b00000, 2'b10);
    add("mm_idle",      P_DONE,  L_MISS, 5'b00000, 2'b00);
    // read request with empty tx FIFO is NACKed
    add("rde_start",    P_START, 5'b11101, 5'b10000, 2'b00);
    add("rde_byte",     P_BYTE,  5'b11101, 5'b00000, 2'b00);
    add("rde_nack",     P_PREP,  5'b11101, 5'b00000, 2'b10);
    add("rde_stop",     P_STOP,  5'b11101, 5'b00000, 2'b00);
    // rx FIFO full on second data byte
    add("ff_start",     P_START, L_WR, 5'b10000, 2'b00);
    add("ff_byte",      P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("ff_addr_ack",  P_PREP,  L_WR, 5'b00000, 2'b01);
    add("ff_rxdata",    P_DONE,  L_WR, 5'b10000, 2'b00);
    add("ff_d0_byte",   P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("ff_d0_push",   P_PREP,  L_WR, 5'b00001, 2'b01);
    add("ff_d0_done",   P_DONE,  L_WR, 5'b10000, 2'b00);
    add("ff_d1_byte",   P_BYTE,  5'b01111, 5'b00000, 2'b00);
    add("ff_d1_nack",   P_PREP,  5'b01111, 5'b00000, 2'b10);
    add("ff_idle",      P_DONE,  5'b01111, 5'b00000, 2'b00);
    // repeated start in RX_DATA, then stop+start together
    add("rs_start",     P_START, L_WR, 5'b10000, 2'b00);
    add("rs_byte",      P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("rs_ack",       P_PREP,  L_WR, 5'b00000, 2'b01);
    add("rs_rxdata",    P_DONE,  L_WR, 5'b10000, 2'b00);
    add("rs_restart",   P_START, L_MISS, 5'b10000, 2'b00);
    add("rs_addr_byte", P_BYTE,  L_MISS, 5'b00000, 2'b00);
    add("rs_is_addr_chk", P_PREP, L_MISS, 5'b00000, 2'b10);
    add("rs_stop_start",6'b110000, L_WR, 5'b00000, 2'b00);
    add("rs_stays_idle",P_NONE,  L_WR, 5'b00000, 2'b00);
    // stop wins over a simultaneous ack_done in ACK_ADDR
    add("pr_start",     P_START, L_WR, 5'b10000, 2'b00);
    add("pr_byte",      P_BYTE,  L_WR, 5'b00000, 2'b00);
    add("pr_ack",       P_PREP,  L_WR, 5'b00000, 2'b01);
    add("pr_stop_done", 6'b010001, L_WR, 5'b00000, 2'b00);

    {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = '0;
    {rw_mode, address_match, sda_in, rx_fifo_full, tx_fifo_empty} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs, 7'b0000000);
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // timeout: sixteen quiet cycles in RX_DATA return to IDLE, not fifteen
    step(mk("to_start",  P_START, L_WR, 5'b10000, 2'b00));
    step(mk("to_byte",   P_BYTE,  L_WR, 5'b00000, 2'b00));
    step(mk("to_ack",    P_PREP,  L_WR, 5'b00000, 2'b01));
    step(mk("to_rxdata", P_DONE,  L_WR, 5'b10000, 2'b00));
    for (int i = 1; i <= 15; i++) step(mk($sformatf("to_wait%0d", i), P_NONE, L_WR, 5'b10000, 2'b00));
    step(mk("to_expired", P_NONE, L_WR, 5'b00000, 2'b00));

    // reset asserted mid TX_DATA clears everything on that edge
    step(mk("mr_start",  P_START, L_RD, 5'b10000, 2'b00));
    step(mk("mr_byte",   P_BYTE,  L_RD, 5'b00000, 2'b00));
    step(mk("mr_ack",    P_PREP,  L_RD, 5'b00000, 2'b01));
    step(mk("mr_load",   P_DONE,  L_RD, 5'b00110, 2'b00));
    step(mk("mr_tx",     P_NONE,  L_RD, 5'b01000, 2'b11));
    rst = 1'b1;
    step(mk("mr_reset",  P_PREP,  L_RD, 5'b00000, 2'b00));
    rst = 1'b0;
    step(mk("mr_post_idle", P_NONE, L_RD, 5'b00000, 2'b00));
    step(mk("mr_restart",   P_START, L_RD, 5'b10000, 2'b00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
